// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: arbitrates the operand-fetch reader and the write-back
// writer onto a single-ported-per-cycle 32x32 register file. READ and WRITE
// are mutually exclusive strobes. Reads take two strobe cycles before data
// is captured. Every operation ends in one ACK cycle.
module rf_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit R0_PROTECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  busy,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;

    localparam logic G_READ  = 1'b0;
    localparam logic G_WRITE = 1'b1;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] lat_addr1;
    logic [ADDR_WIDTH-1:0] lat_addr2;
    logic [ADDR_WIDTH-1:0] lat_waddr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  hazard;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  wr_skip;

    // Arbitration: a lone request wins; with both pending a write that aliases
    // either read address goes first, otherwise round-robin on last_grant.
    always_comb begin
        hazard   = (wr_addr == rd_addr1) || (wr_addr == rd_addr2);
        wr_skip  = R0_PROTECT && (wr_addr == '0);
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rd_req && wr_req) begin
            if (hazard) begin
                grant_wr = 1'b1;
            end else if (last_grant == G_WRITE) begin
                grant_rd = 1'b1;
            end else begin
                grant_wr = 1'b1;
            end
        end else if (rd_req) begin
            grant_rd = 1'b1;
        end else if (wr_req) begin
            grant_wr = 1'b1;
        end
    end

    // Next-state logic; a protected R0 write skips the WR strobe entirely.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: begin
                if (grant_rd) begin
                    state_nxt = S_RD1;
                end else if (grant_wr) begin
                    state_nxt = wr_skip ? S_ACK : S_WR;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD1:   state_nxt = S_RD2;
            S_RD2:   state_nxt = S_ACK;
            S_WR:    state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, grant history, operand latches and captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= G_WRITE;
            lat_addr1  <= '0;
            lat_addr2  <= '0;
            lat_waddr  <= '0;
            lat_wdata  <= '0;
            rd_data1   <= '0;
            rd_data2   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && grant_rd) begin
                lat_addr1  <= rd_addr1;
                lat_addr2  <= rd_addr2;
                last_grant <= G_READ;
            end
            if (state == S_IDLE && grant_wr) begin
                lat_waddr  <= wr_addr;
                lat_wdata  <= wr_data;
                last_grant <= G_WRITE;
            end
            if (state == S_RD2) begin
                rd_data1 <= rf_data_r1;
                rd_data2 <= rf_data_r2;
            end
        end
    end

    // Strobes, gated file buses and ACKs decoded from the current state;
    // last_grant tells the ACK cycle which operation it is closing.
    always_comb begin
        rf_read    = (state == S_RD1) || (state == S_RD2);
        rf_write   = (state == S_WR);
        rf_addr_r1 = rf_read  ? lat_addr1 : '0;
        rf_addr_r2 = rf_read  ? lat_addr2 : '0;
        rf_addr_w  = rf_write ? lat_waddr : '0;
        rf_data_w  = rf_write ? lat_wdata : '0;
        rd_ack     = (state == S_ACK) && (last_grant == G_READ);
        wr_ack     = (state == S_ACK) && (last_grant == G_WRITE);
        busy       = (state != S_IDLE);
    end

endmodule
